pll_reconfig_ctrl: RTL

Sequencer for the dynamic-control ports of a Gowin GW5A PLL instance. It runs on the fabric system clock and applies divider codes on the IDSEL, FBDSEL, MDSEL and ODSEL0 ports. It also drives PLL reset, qualifies LOCK, and gates CLKOUT0 through ENCLK0. It re-locks automatically after loss of lock and reports a fault after repeated lock timeouts.

---
 rtl/pll_reconfig_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pll_reconfig_ctrl.sv
// Sequencer for the dynamic-control ports of a GW5A PLL: applies divider codes,
// pulses PLL reset, qualifies LOCK, gates CLKOUT0 and retries on lock timeout.
module pll_reconfig_ctrl #(
  parameter int         RST_CYCLES          = 16,
  parameter int         LOCK_STABLE_CYCLES  = 1024,
  parameter int         LOCK_TIMEOUT_CYCLES = 65536,
  parameter int         MAX_RETRY           = 3,
  parameter int         GATE_CYCLES         = 4,
  parameter int         CNT_W               = 17,
  parameter logic [5:0] DEF_IDSEL           = 6'd0,
  parameter logic [5:0] DEF_FBDSEL          = 6'd0,
  parameter logic [6:0] DEF_MDSEL           = 7'd0,
  parameter logic [6:0] DEF_ODSEL0          = 7'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [6:0] cfg_mdsel,
  input  logic [6:0] cfg_odsel0,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [6:0] pll_mdsel,
  output logic [6:0] pll_odsel0,
  output logic       clk_en,
  output logic       locked,
  output logic       busy,
  output logic       err,
  output logic [7:0] lost_lock_cnt
);

  typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, RUN, GATE, FAULT} state_t;

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GATE_LAST    = CNT_W'(GATE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   stable_cnt, stable_n;
  logic [RETRY_W-1:0] retry, retry_n, retry_inc;
  logic [7:0]         lost_n;
  logic               load_cfg, accept;
  logic               lock_meta, lock_s;
  logic               pll_reset_d, clk_en_d, locked_d, busy_d, err_d, cfg_ready_d;

  assign accept    = cfg_valid && cfg_ready;
  assign retry_inc = retry + RETRY_W'(1);

  // LOCK comes from the PLL's own clock domain, so it is double-flopped first.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RST_PLL;
      cnt           <= '0;
      stable_cnt    <= '0;
      retry         <= '0;
      lost_lock_cnt <= 8'd0;
      pll_idsel     <= DEF_IDSEL;
      pll_fbdsel    <= DEF_FBDSEL;
      pll_mdsel     <= DEF_MDSEL;
      pll_odsel0    <= DEF_ODSEL0;
      pll_reset     <= 1'b1;
      clk_en        <= 1'b0;
      locked        <= 1'b0;
      busy          <= 1'b1;
      err           <= 1'b0;
      cfg_ready     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      stable_cnt    <= stable_n;
      retry         <= retry_n;
      lost_lock_cnt <= lost_n;
      if (load_cfg) begin
        pll_idsel  <= cfg_idsel;
        pll_fbdsel <= cfg_fbdsel;
        pll_mdsel  <= cfg_mdsel;
        pll_odsel0 <= cfg_odsel0;
      end
      pll_reset <= pll_reset_d;
      clk_en    <= clk_en_d;
      locked    <= locked_d;
      busy      <= busy_d;
      err       <= err_d;
      cfg_ready <= cfg_ready_d;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stable_n = stable_cnt;
    retry_n  = retry;
    lost_n   = lost_lock_cnt;
    load_cfg = 1'b0;
    unique case (state)
      RST_PLL: begin
        if (cnt == RST_LAST) begin
          state_n  = WAIT_LOCK;
          cnt_n    = '0;
          stable_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      // A stable lock wins over a timeout landing on the same cycle.
      WAIT_LOCK: begin
        if (lock_s && (stable_cnt == STABLE_LAST)) begin
          state_n  = RUN;
          retry_n  = '0;
          cnt_n    = '0;
          stable_n = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_n  = retry_inc;
          cnt_n    = '0;
          stable_n = '0;
          state_n  = (retry_inc == RETRY_LIMIT) ? FAULT : RST_PLL;
        end else begin
          cnt_n    = cnt + CNT_W'(1);
          stable_n = lock_s ? stable_cnt + CNT_W'(1) : '0;
        end
      end
      RUN: begin
        load_cfg = accept;
        if (!lock_s) begin
          state_n = RST_PLL;
          cnt_n   = '0;
          if (lost_lock_cnt != 8'hFF) lost_n = lost_lock_cnt + 8'd1;
        end else if (accept) begin
          state_n = GATE;
          cnt_n   = '0;
        end
      end
      GATE: begin
        if (cnt == GATE_LAST) begin
          state_n = RST_PLL;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      FAULT: begin
        if (accept) begin
          load_cfg = 1'b1;
          retry_n  = '0;
          state_n  = RST_PLL;
          cnt_n    = '0;
        end
      end
      default: state_n = RST_PLL;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies track the state register.
  always_comb begin
    pll_reset_d = (state_n == RST_PLL) || (state_n == FAULT);
    clk_en_d    = (state_n == RUN);
    locked_d    = (state_n == RUN);
    busy_d      = (state_n != RUN) && (state_n != FAULT);
    err_d       = (state_n == FAULT);
    cfg_ready_d = (state_n == RUN) || (state_n == FAULT);
  end

endmodule
